// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a WIDTH-bit word on a valid/ready
// handshake and streams it MSB-first under shift_en pacing. Optional macro
// PISO_PARITY_EN appends one even-parity bit after the data bits.
module piso_serializer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             s_out,
   output logic             s_valid,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH + 1);

`ifdef PISO_PARITY_EN
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);
`else
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CNT_W-1:0] cnt;
   logic             last_bit;
   logic             accept;
   logic             advance;
   logic             fill_bit;

   assign last_bit = (state == SHIFT) && (cnt == LAST_CNT);
   assign advance  = (state == SHIFT) && shift_en;
   assign accept   = load_valid && load_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A load on the final bit takes precedence over the return to IDLE.
   always_comb begin
      state_nxt  = state;
      load_ready = 1'b0;
      s_valid    = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            load_ready = 1'b1;
            if (load_valid) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            busy    = 1'b1;
            s_valid = shift_en;
            if (last_bit && shift_en) begin
               done       = 1'b1;
               load_ready = 1'b1;
               state_nxt  = load_valid ? SHIFT : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef PISO_PARITY_EN
   // Parity is captured with the word and shifted in behind the last data bit,
   // so it reaches the MSB exactly in slot WIDTH.
   logic par_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_bit <= 1'b0;
      end else if (accept) begin
         par_bit <= ^data_in;
      end else if (advance) begin
         par_bit <= 1'b0;
      end
   end

   assign fill_bit = par_bit;
`else
   assign fill_bit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
         cnt  <= '0;
      end else if (accept) begin
         sreg <= data_in;
         cnt  <= '0;
      end else if (advance) begin
         sreg <= {sreg[WIDTH-2:0], fill_bit};
         cnt  <= cnt + 1'b1;
      end
   end

   assign s_out = sreg[WIDTH-1];

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed scenarios plus random
// traffic against a queue-of-bits reference model.
module tb_piso_serializer;
   localparam int WIDTH = 4;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [WIDTH-1:0] data_in;
   logic             load_valid;
   logic             load_ready;
   logic             shift_en;
   logic             s_out;
   logic             s_valid;
   logic             busy;
   logic             done;

   piso_serializer #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .shift_en   (shift_en),
      .s_out      (s_out),
      .s_valid    (s_valid),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference: the bits still to be emitted for the current word, front first.
   bit               exp_q[$];
   logic [WIDTH-1:0] cur_word = '0;
   logic [WIDTH-1:0] ds_reg   = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_load(input logic [WIDTH-1:0] w);
      exp_q.delete();
      for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PISO_PARITY_EN
      exp_q.push_back(^w);
`endif
      cur_word = w;
   endtask

   // One clock cycle: entered just after a rising edge, leaves just after the next.
   task automatic cyc(input logic lv, input logic [WIDTH-1:0] d, input logic se);
      bit b, lst, acc, cur;
      load_valid = lv;
      data_in    = d;
      shift_en   = se;
      @(negedge clk);
      b   = (exp_q.size() > 0);
      lst = (exp_q.size() == 1);
      cur = b ? exp_q[0] : 1'b0;
      check("busy",       busy,       b);
      check("s_valid",    s_valid,    b && se);
      check("done",       done,       lst && se);
      check("load_ready", load_ready, !b || (lst && se));
      check("s_out",      s_out,      cur);
      acc = lv && (!b || (lst && se));
      @(posedge clk);
      if (b && se) ds_reg = {ds_reg[WIDTH-2:0], cur};
`ifndef PISO_PARITY_EN
      if (lst && se) check("q_out", ds_reg, cur_word);
`endif
      if (acc) model_load(d);
      else if (b && se) void'(exp_q.pop_front());
      #1;
   endtask

   task automatic reset_mid_cycle();
      load_valid = 1'b0;
      shift_en   = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check("rst_s_out",   s_out,   1'b0);
      check("rst_s_valid", s_valid, 1'b0);
      check("rst_busy",    busy,    1'b0);
      check("rst_done",    done,    1'b0);
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_load_ready", load_ready, 1'b1);
   endtask

   initial begin
      rst_n      = 1'b0;
      load_valid = 1'b0;
      data_in    = '0;
      shift_en   = 1'b0;
      #2;
      check("init_s_out",   s_out,   1'b0);
      check("init_s_valid", s_valid, 1'b0);
      check("init_busy",    busy,    1'b0);
      check("init_done",    done,    1'b0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("init_load_ready", load_ready, 1'b1);

      // Basic word
      cyc(1'b1, 4'b1011, 1'b1);
      repeat (WIDTH + 2) cyc(1'b0, 4'h0, 1'b1);

      // Back-to-back with load_valid held; extra requests while busy are ignored
      cyc(1'b1, 4'hA, 1'b1);
      repeat (WIDTH) cyc(1'b1, 4'h5, 1'b1);
      repeat (WIDTH + 1) cyc(1'b0, 4'h0, 1'b1);

      // Stall in the middle of a word
      cyc(1'b1, 4'b1100, 1'b1);
      cyc(1'b0, 4'h0, 1'b1);
      cyc(1'b0, 4'h0, 1'b0);
      cyc(1'b0, 4'h0, 1'b0);
      repeat (WIDTH + 1) cyc(1'b0, 4'h0, 1'b1);

      // Reset in the middle of a word
      cyc(1'b1, 4'b1111, 1'b1);
      cyc(1'b0, 4'h0, 1'b1);
      reset_mid_cycle();
      repeat (WIDTH + 1) cyc(1'b0, 4'h0, 1'b1);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 99) == 0) begin
            reset_mid_cycle();
         end else begin
            cyc(1'($urandom_range(0, 1)), WIDTH'($urandom),
                1'($urandom_range(0, 3) != 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
